// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter, 8 data bits LSB first, CLKS_PER_BIT clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             bit_done;
    logic             accept;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg;
`endif

    assign bit_done = (cnt_reg == CNT_LAST);
    assign accept   = (state_reg == ST_IDLE) && i_start;

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done && (bit_idx_reg == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Baud counter restarts at every bit boundary; it is held at zero while idle
    // so the start bit gets a full period from the cycle after acceptance.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            if ((state_reg == ST_IDLE) || bit_done) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            if (state_reg != ST_DATA) begin
                bit_idx_reg <= '0;
            end else if (bit_done) begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end

            if (accept) begin
                shift_reg <= i_data;
            end else if ((state_reg == ST_DATA) && bit_done) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte as accepted, since the shift register empties.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            parity_reg <= 1'b0;
        end else if (accept) begin
            parity_reg <= ^i_data;
        end
    end
`endif

    always_comb begin
        o_tx   = 1'b1;
        o_busy = 1'b1;
        o_done = 1'b0;
        case (state_reg)
            ST_IDLE:   o_busy = 1'b0;
            ST_START:  o_tx   = 1'b0;
            ST_DATA:   o_tx   = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: o_tx   = parity_reg;
`endif
            ST_STOP:   o_done = bit_done;
            default:   o_busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx at CLKS_PER_BIT = 4; a negedge monitor
// reconstructs each frame and compares it against a queue of expected frames.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;
    localparam int MAXC      = 64;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .i_start   (i_start),
        .i_data    (i_data),
        .o_tx      (o_tx),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;   // transmission order, leftmost bit sent first
        logic       par;
    } vec_t;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [15:0] exp_q[$];
    int   frames_seen = 0;
    int   gap_cnt     = 0;
    int   last_gap    = 0;
    int   busy_len    = 0;
    int   done_cnt    = 0;
    int   done_pos    = -1;
    int   spurious    = 0;
    bit   in_frame    = 1'b0;
    logic line_s [0:MAXC-1];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] frame_from_seq(input logic [7:0] seq, input logic par);
        logic [15:0] f;
        f = '0;
        for (int k = 0; k < 8; k++) f[1+k] = seq[7-k];
`ifdef UART_TX_PARITY_EN
        f[9]  = par;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1 | par;
`endif
        return f;
    endfunction

    task automatic finish_frame();
        logic [15:0] got;
        logic [15:0] exp;
        bit          stable;
        got    = '0;
        exp    = '0;
        stable = 1'b1;
        for (int b = 0; b < NBITS; b++) begin
            got[b] = line_s[b*CPB];
            for (int k = 1; k < CPB; k++)
                if (line_s[b*CPB+k] !== line_s[b*CPB]) stable = 1'b0;
        end
        check("frame_queued", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        frames_seen++;
        $display("frame %0d: bits %h expected %h busy %0d done_at %0d", frames_seen, got, exp, busy_len, done_pos);
        check("frame_bits", 32'(got), 32'(exp));
        check("frame_bit_stable", 32'(stable), 32'd1);
        check("frame_busy_len", busy_len, FRAME_CYC);
        check("frame_done_count", done_cnt, 1);
        check("frame_done_pos", done_pos, FRAME_CYC - 1);
    endtask

    always @(negedge clk) begin
        if (i_reset_n !== 1'b1) begin
            if (in_frame && done_cnt != 0) spurious++;
            in_frame = 1'b0;
            gap_cnt  = 0;
        end else begin
            if (in_frame && o_busy !== 1'b1) begin
                finish_frame();
                in_frame = 1'b0;
            end
            if (!in_frame && o_busy === 1'b1) begin
                in_frame = 1'b1;
                busy_len = 0;
                done_cnt = 0;
                done_pos = -1;
                last_gap = gap_cnt;
                gap_cnt  = 0;
                for (int i = 0; i < MAXC; i++) line_s[i] = 1'bx;
            end
            if (in_frame) begin
                if (busy_len < MAXC) line_s[busy_len] = o_tx;
                if (o_done === 1'b1) begin
                    done_cnt++;
                    done_pos = busy_len;
                end
                busy_len++;
            end else begin
                gap_cnt++;
                if (o_tx !== 1'b1 || o_done !== 1'b0) spurious++;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [15:0] exp);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_data  = d;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_done !== 1'b1 && n < budget);
        check("done_seen", 32'(o_done), 32'd1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("frames_completed", frames_seen, target);
    endtask

    vec_t vecs[9];
    int   n0;

    initial begin
        vecs[0] = '{data: 8'h50, seq: 8'b0000_1010, par: 1'b0};
        vecs[1] = '{data: 8'hFF, seq: 8'b1111_1111, par: 1'b0};
        vecs[2] = '{data: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
        vecs[3] = '{data: 8'h3C, seq: 8'b0011_1100, par: 1'b0};
        vecs[4] = '{data: 8'h01, seq: 8'b1000_0000, par: 1'b1};
        vecs[5] = '{data: 8'h81, seq: 8'b1000_0001, par: 1'b0};
        vecs[6] = '{data: 8'h00, seq: 8'b0000_0000, par: 1'b0};
        vecs[7] = '{data: 8'h80, seq: 8'b0000_0001, par: 1'b1};
        vecs[8] = '{data: 8'h0F, seq: 8'b1111_0000, par: 1'b0};

        // Asynchronous reset mid-cycle, then idle after release.
        @(posedge clk); #2;
        i_reset_n = 1'b0;
        #1;
        check("reset_tx", 32'(o_tx), 32'd1);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        repeat (3) @(posedge clk);
        #3 i_reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_tx", 32'(o_tx), 32'd1);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_done", 32'(o_done), 32'd0);

        // Single frames from the vector table.
        for (int i = 0; i < 9; i++) begin
            n0 = frames_seen;
            send(vecs[i].data, frame_from_seq(vecs[i].seq, vecs[i].par));
            wait_frames(n0 + 1, 200);
            repeat (3) @(posedge clk);
        end

        // Starts during a frame and in the done cycle are ignored.
        n0 = frames_seen;
        send(8'hFF, frame_from_seq(8'b1111_1111, 1'b0));
        repeat (9) @(posedge clk);
        #1;
        i_start = 1'b1;
        i_data  = 8'h00;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_done(200);
        i_start = 1'b1;
        i_data  = 8'h00;
        @(posedge clk); #1;
        i_start = 1'b0;
        wait_frames(n0 + 1, 200);
        repeat (50) @(posedge clk);
        check("ignore_no_extra_frame", frames_seen, n0 + 1);

        // Back-to-back frames with a single idle cycle between them.
        n0 = frames_seen;
        send(8'hA5, frame_from_seq(8'b1010_0101, 1'b0));
        wait_done(200);
        send(8'h3C, frame_from_seq(8'b0011_1100, 1'b0));
        wait_frames(n0 + 2, 200);
        check("b2b_gap", last_gap, 1);
        repeat (5) @(posedge clk);

        // Reset during data bit 3 abandons the frame.
        n0 = frames_seen;
        send(8'h0F, frame_from_seq(8'b1111_0000, 1'b0));
        repeat (17) @(posedge clk);
        #3;
        check("mid_frame_busy", 32'(o_busy), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("mid_reset_tx", 32'(o_tx), 32'd1);
        check("mid_reset_busy", 32'(o_busy), 32'd0);
        check("mid_reset_done", 32'(o_done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 i_reset_n = 1'b1;
        repeat (30) @(posedge clk);
        check("aborted_frame_not_completed", frames_seen, n0);
        send(8'h01, frame_from_seq(8'b1000_0000, 1'b1));
        wait_frames(n0 + 1, 200);
        repeat (3) @(posedge clk);

        // i_data changing every cycle after acceptance.
        n0 = frames_seen;
        send(8'h81, frame_from_seq(8'b1000_0001, 1'b0));
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            i_data = 8'($urandom);
        end
        wait_frames(n0 + 1, 200);

        // i_start held high restarts at every return to idle.
        n0 = frames_seen;
        @(posedge clk); #1;
        i_start = 1'b1;
        i_data  = 8'h55;
        exp_q.push_back(frame_from_seq(8'b1010_1010, 1'b0));
        exp_q.push_back(frame_from_seq(8'b1010_1010, 1'b0));
        wait_done(200);
        wait_done(200);
        i_start = 1'b0;
        wait_frames(n0 + 2, 200);
        check("held_start_gap", last_gap, 1);
        repeat (20) @(posedge clk);

        check("no_spurious_line_activity", spurious, 0);
        check("expected_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART serial transmitter; sits directly downstream of the up-counter, which emits a one-cycle start strobe plus an 8-bit data byte (ASCII 'P', 80 decimal) once per second.
- Accepts a byte on a start strobe, serialises it LSB-first onto the TX line at a fixed baud rate, and reports busy and done status.
- Output drives the board UART TX pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range is ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  transmit request, sampled on the rising edge of clk.
- i_data  input  8  byte to send; captured in the same cycle i_start is accepted.
- o_tx  output  1  serial line; idles high.
- o_busy  output  1  high while a frame is in progress.
- o_done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Clock and reset: one clock, clk. Reset i_reset_n is asynchronous and active-low.
- Reset values, forced immediately on reset assertion:
  - o_tx = 1, o_busy = 0, o_done = 0.
  - State = IDLE; bit counter, bit index and shift register all cleared.
- States:
  - IDLE -> START -> DATA -> STOP -> IDLE.
  - With UART_TX_PARITY_EN defined: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- Baud timing:
  - Counter width is $clog2(CLKS_PER_BIT).
  - Each bit state holds o_tx for exactly CLKS_PER_BIT cycles: counter runs 0 .. CLKS_PER_BIT-1, then the state advances and the counter returns to 0.
- IDLE:
  - o_tx = 1, o_busy = 0.
  - On i_start = 1 at an edge: latch i_data into the shift register and go to START.
  - From the next cycle, o_tx = 0 and o_busy = 1. Accept-to-start-bit latency is 1 cycle.
- START: o_tx = 0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA:
  - o_tx = latched bit[index], with index 0 = least significant bit (weight 1).
  - Index increments after each bit period; after index 7 completes, go to STOP (or PARITY).
- STOP:
  - o_tx = 1 for CLKS_PER_BIT cycles.
  - o_done = 1 during the final cycle of STOP only; the next state is IDLE with o_busy = 0.
- Frame length: exactly 10 × CLKS_PER_BIT cycles from the first o_tx = 0 cycle to the cycle o_busy falls.
- Handshake rules:
  - i_start is honoured only in IDLE. i_start while busy, including the o_done cycle, is ignored and not queued.
  - i_data changes after acceptance do not affect the frame in progress.
- Back-to-back frames: i_start asserted in the first IDLE cycle after o_done starts the next frame. The minimum line-idle gap between frames is 1 cycle.
- Reset mid-frame: the frame is abandoned, o_tx returns high immediately, and no o_done is generated.
- i_start held high continuously: a new frame starts at every return to IDLE.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - o_tx = even parity, i.e. the XOR of the 8 latched data bits, for CLKS_PER_BIT cycles.
  - Frame length becomes 11 × CLKS_PER_BIT cycles.
- When undefined: no PARITY state, 8N1 framing, no parity logic synthesised.

Test Plan:
- Run the bench with CLKS_PER_BIT = 4.
1. Reset then idle: assert i_reset_n = 0 asynchronously mid-cycle -> o_tx = 1, o_busy = 0, o_done = 0 immediately; they hold after release with i_start = 0.
2. Send 0x50 (ASCII 'P'): pulse i_start one cycle with i_data = 0x50 -> o_tx holds each bit 4 cycles: 0 (start), then 0,0,0,0,1,0,1,0, then 1 (stop).
   - o_busy is high for 40 cycles; o_done pulses once, in cycle 40.
   - With UART_TX_PARITY_EN: a parity bit 0 is inserted before stop, and o_busy is high for 44 cycles.
3. Ignore while busy: start 0xFF, then pulse i_start with 0x00 at cycle 10 and again in the o_done cycle -> only the 0xFF frame is transmitted (start, eight 1s, stop); o_tx stays 1 afterwards.
4. Back-to-back: 0xA5 then 0x3C, with the second i_start in the first IDLE cycle after o_done -> the two frames are separated by exactly 1 high idle cycle.
   - Bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
   - With UART_TX_PARITY_EN: parity bits are 0 and 0.
5. Reset mid-frame: assert i_reset_n = 0 during data bit 3 of 0x0F -> o_tx = 1 immediately and o_done never pulses.
   - After release, a new 0x01 frame transmits correctly: 0,1,0,0,0,0,0,0,0,1.
6. Data stability: change i_data every cycle after accepting 0x81 -> the serialised bits remain 1,0,0,0,0,0,0,1.
   - With UART_TX_PARITY_EN: parity bit 0.
